// File: rtl/timing_control_unit.sv
// timing_control_unit: basic-computer sequence counter, T/D/I/S registers and per-cycle strobes.
// Interrupt cycle (R flip-flop, RT0..RT2) is built only when INTERRUPT_EN is defined.
module timing_control_unit (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        START,
  input  logic [15:0] IR,
  input  logic        DR_ZERO,
  input  logic        FGI,
  input  logic        FGO,
  input  logic        IEN,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic        I,
  output logic        RUN,
  output logic [2:0]  BUS_SEL,
  output logic        AR_LD,
  output logic        AR_INR,
  output logic        AR_CLR,
  output logic        PC_LD,
  output logic        PC_INR,
  output logic        PC_CLR,
  output logic        DR_LD,
  output logic        DR_INR,
  output logic        AC_LD,
  output logic        IR_LD,
  output logic        TR_LD,
  output logic        MEM_WR,
  output logic        IEN_CLR,
  output logic [2:0]  ALU_OP,
  output logic        REG_EXEC,
  output logic        IO_EXEC
);
  logic [2:0] sc;
  logic       r;
  logic       sc_clr;
  logic       hlt;
  logic       unused_in;
  assign T = 8'd1 << sc;
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sc  <= 3'd0;
      D   <= 8'd0;
      I   <= 1'b0;
      RUN <= 1'b0;
    end else if (!RUN) begin
      RUN <= START;
    end else begin
      sc <= sc_clr ? 3'd0 : sc + 3'd1;
      if (T[2] && !r) begin
        D <= 8'd1 << IR[14:12];
        I <= IR[15];
      end
      if (hlt) RUN <= 1'b0;
    end
  end
`ifdef INTERRUPT_EN
  always_ff @(posedge CLK) begin
    if (CLR) r <= 1'b0;
    else if (RUN && r && T[2]) r <= 1'b0;
    else if (RUN && IEN && (FGI || FGO) && !(|T[2:0])) r <= 1'b1;
  end
  assign unused_in = ^IR[11:1];
`else
  assign r = 1'b0;
  assign unused_in = ^{IR[11:1], FGI, FGO, IEN};
`endif
  always_comb begin
    BUS_SEL  = 3'd0;
    AR_LD    = 1'b0;
    AR_INR   = 1'b0;
    AR_CLR   = 1'b0;
    PC_LD    = 1'b0;
    PC_INR   = 1'b0;
    PC_CLR   = 1'b0;
    DR_LD    = 1'b0;
    DR_INR   = 1'b0;
    AC_LD    = 1'b0;
    IR_LD    = 1'b0;
    TR_LD    = 1'b0;
    MEM_WR   = 1'b0;
    IEN_CLR  = 1'b0;
    ALU_OP   = 3'd0;
    REG_EXEC = 1'b0;
    IO_EXEC  = 1'b0;
    sc_clr   = 1'b0;
    hlt      = 1'b0;
    if (RUN) begin
      if (|T[2:0]) begin
`ifdef INTERRUPT_EN
        if (r) begin
          AR_CLR  = T[0];
          TR_LD   = T[0];
          MEM_WR  = T[1];
          PC_CLR  = T[1];
          PC_INR  = T[2];
          IEN_CLR = T[2];
          sc_clr  = T[2];
          BUS_SEL = T[0] ? 3'd2 : T[1] ? 3'd6 : 3'd0;
        end else
`endif
        begin
          AR_LD   = T[0] | T[2];
          IR_LD   = T[1];
          PC_INR  = T[1];
          BUS_SEL = T[0] ? 3'd2 : T[1] ? 3'd7 : 3'd5;
        end
      end else if (T[3]) begin
        if (D[7]) begin
          sc_clr   = 1'b1;
          REG_EXEC = !I;
          IO_EXEC  = I;
          hlt      = !I && IR[0];
        end else if (I) begin
          BUS_SEL = 3'd7;
          AR_LD   = 1'b1;
        end
      end else if (T[4]) begin
        if (D[0] || D[1] || D[2] || D[6]) begin
          BUS_SEL = 3'd7;
          DR_LD   = 1'b1;
        end else if (D[3]) begin
          BUS_SEL = 3'd4;
          MEM_WR  = 1'b1;
          sc_clr  = 1'b1;
        end else if (D[4]) begin
          BUS_SEL = 3'd1;
          PC_LD   = 1'b1;
          sc_clr  = 1'b1;
        end else if (D[5]) begin
          BUS_SEL = 3'd2;
          MEM_WR  = 1'b1;
          AR_INR  = 1'b1;
        end
      end else if (T[5]) begin
        if (|D[2:0]) begin
          AC_LD  = 1'b1;
          ALU_OP = D[0] ? 3'd1 : D[1] ? 3'd2 : 3'd3;
          sc_clr = 1'b1;
        end else if (D[5]) begin
          BUS_SEL = 3'd1;
          PC_LD   = 1'b1;
          sc_clr  = 1'b1;
        end else if (D[6]) begin
          DR_INR = 1'b1;
        end
      end else if (T[6] && D[6]) begin
        BUS_SEL = 3'd3;
        MEM_WR  = 1'b1;
        PC_INR  = DR_ZERO;
        sc_clr  = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_timing_control_unit.sv
// tb_timing_control_unit: directed instruction sequences with a queue of expected per-cycle outputs.
module tb_timing_control_unit;
  logic        CLK = 1'b0;
  logic        CLR, START, DR_ZERO, FGI, FGO, IEN;
  logic [15:0] IR;
  logic [7:0]  T, D;
  logic        I, RUN;
  logic [2:0]  BUS_SEL, ALU_OP;
  logic        AR_LD, AR_INR, AR_CLR, PC_LD, PC_INR, PC_CLR, DR_LD, DR_INR;
  logic        AC_LD, IR_LD, TR_LD, MEM_WR, IEN_CLR, REG_EXEC, IO_EXEC;
  localparam logic [14:0] S_AR_LD = 15'h4000, S_AR_INR = 15'h2000, S_AR_CLR = 15'h1000;
  localparam logic [14:0] S_PC_LD = 15'h0800, S_PC_INR = 15'h0400, S_PC_CLR = 15'h0200;
  localparam logic [14:0] S_DR_LD = 15'h0100, S_DR_INR = 15'h0080, S_AC_LD = 15'h0040;
  localparam logic [14:0] S_IR_LD = 15'h0020, S_TR_LD = 15'h0010, S_MEM_WR = 15'h0008;
  localparam logic [14:0] S_IEN_CLR = 15'h0004, S_REG = 15'h0002, S_IO = 15'h0001;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_d = 8'd0;
  logic        exp_i = 1'b0;
  logic        exp_run = 1'b0;
  string       tag_q[$];
  logic [38:0] exp_q[$];

  timing_control_unit dut (
    .CLK(CLK), .CLR(CLR), .START(START), .IR(IR), .DR_ZERO(DR_ZERO),
    .FGI(FGI), .FGO(FGO), .IEN(IEN), .T(T), .D(D), .I(I), .RUN(RUN),
    .BUS_SEL(BUS_SEL), .AR_LD(AR_LD), .AR_INR(AR_INR), .AR_CLR(AR_CLR),
    .PC_LD(PC_LD), .PC_INR(PC_INR), .PC_CLR(PC_CLR), .DR_LD(DR_LD),
    .DR_INR(DR_INR), .AC_LD(AC_LD), .IR_LD(IR_LD), .TR_LD(TR_LD),
    .MEM_WR(MEM_WR), .IEN_CLR(IEN_CLR), .ALU_OP(ALU_OP),
    .REG_EXEC(REG_EXEC), .IO_EXEC(IO_EXEC)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input string tag, input logic [7:0] t, input logic [2:0] bus,
                     input logic [14:0] stb, input logic [2:0] alu);
    string       e_tag;
    logic [38:0] e_v, obs;
    tag_q.push_back(tag);
    exp_q.push_back({t, exp_d, exp_i, exp_run, bus, stb, alu});
    @(negedge CLK);
    e_tag = tag_q.pop_front();
    e_v   = exp_q.pop_front();
    obs = {T, D, I, RUN, BUS_SEL, AR_LD, AR_INR, AR_CLR, PC_LD, PC_INR, PC_CLR,
           DR_LD, DR_INR, AC_LD, IR_LD, TR_LD, MEM_WR, IEN_CLR, REG_EXEC, IO_EXEC, ALU_OP};
    checks++;
    assert (obs === e_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e_tag, obs, e_v);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ir);
    IR = ir;
    cyc("fetch_t0", 8'h01, 3'd2, S_AR_LD, 3'd0);
    cyc("fetch_t1", 8'h02, 3'd7, S_IR_LD | S_PC_INR, 3'd0);
    cyc("fetch_t2", 8'h04, 3'd5, S_AR_LD, 3'd0);
    exp_d = 8'd1 << ir[14:12];
    exp_i = ir[15];
  endtask

  initial begin
    CLR = 1'b1; START = 1'b0; IR = 16'h0000; DR_ZERO = 1'b0;
    FGI = 1'b0; FGO = 1'b0; IEN = 1'b0;
    @(posedge CLK);
    #1;
    cyc("reset", 8'h01, 3'd0, 15'd0, 3'd0);
    CLR = 1'b0; START = 1'b1;
    cyc("idle_start", 8'h01, 3'd0, 15'd0, 3'd0);
    START = 1'b0; exp_run = 1'b1;
    fetch(16'h1005);
    cyc("add_t3", 8'h08, 3'd0, 15'd0, 3'd0);
    cyc("add_t4", 8'h10, 3'd7, S_DR_LD, 3'd0);
    cyc("add_t5", 8'h20, 3'd0, S_AC_LD, 3'd2);
    fetch(16'h8123);
    cyc("and_ind_t3", 8'h08, 3'd7, S_AR_LD, 3'd0);
    cyc("and_t4", 8'h10, 3'd7, S_DR_LD, 3'd0);
    cyc("and_t5", 8'h20, 3'd0, S_AC_LD, 3'd1);
    fetch(16'h2010);
    cyc("lda_t3", 8'h08, 3'd0, 15'd0, 3'd0);
    cyc("lda_t4", 8'h10, 3'd7, S_DR_LD, 3'd0);
    cyc("lda_t5", 8'h20, 3'd0, S_AC_LD, 3'd3);
    for (int z = 1; z >= 0; z--) begin
      fetch(16'h6040);
      DR_ZERO = z[0];
      cyc("isz_t3", 8'h08, 3'd0, 15'd0, 3'd0);
      cyc("isz_t4", 8'h10, 3'd7, S_DR_LD, 3'd0);
      cyc("isz_t5", 8'h20, 3'd0, S_DR_INR, 3'd0);
      cyc(z ? "isz_t6_zero" : "isz_t6_nonzero", 8'h40, 3'd3, S_MEM_WR | (z ? S_PC_INR : 15'd0), 3'd0);
    end
    fetch(16'h3010);
    cyc("sta_t3", 8'h08, 3'd0, 15'd0, 3'd0);
    cyc("sta_t4", 8'h10, 3'd4, S_MEM_WR, 3'd0);
    fetch(16'h4020);
    cyc("bun_t3", 8'h08, 3'd0, 15'd0, 3'd0);
    cyc("bun_t4", 8'h10, 3'd1, S_PC_LD, 3'd0);
    fetch(16'hF800);
    cyc("io_t3", 8'h08, 3'd0, S_IO, 3'd0);
`ifdef INTERRUPT_EN
    fetch(16'h1005);
    cyc("irq_add_t3", 8'h08, 3'd0, 15'd0, 3'd0);
    IEN = 1'b1; FGI = 1'b1;
    cyc("irq_add_t4", 8'h10, 3'd7, S_DR_LD, 3'd0);
    IEN = 1'b0; FGI = 1'b0;
    cyc("irq_add_t5", 8'h20, 3'd0, S_AC_LD, 3'd2);
    cyc("rt0", 8'h01, 3'd2, S_AR_CLR | S_TR_LD, 3'd0);
    cyc("rt1", 8'h02, 3'd6, S_MEM_WR | S_PC_CLR, 3'd0);
    cyc("rt2", 8'h04, 3'd0, S_PC_INR | S_IEN_CLR, 3'd0);
`endif
    fetch(16'h5010);
    cyc("bsa_t3", 8'h08, 3'd0, 15'd0, 3'd0);
    cyc("bsa_t4", 8'h10, 3'd2, S_MEM_WR | S_AR_INR, 3'd0);
    CLR = 1'b1;
    cyc("bsa_t5_clr", 8'h20, 3'd1, S_PC_LD, 3'd0);
    CLR = 1'b0; exp_run = 1'b0; exp_d = 8'd0; exp_i = 1'b0;
    cyc("after_clr", 8'h01, 3'd0, 15'd0, 3'd0);
    CLR = 1'b1; START = 1'b1;
    cyc("clr_and_start", 8'h01, 3'd0, 15'd0, 3'd0);
    CLR = 1'b0; START = 1'b0;
    cyc("clr_beats_start", 8'h01, 3'd0, 15'd0, 3'd0);
    START = 1'b1;
    cyc("restart", 8'h01, 3'd0, 15'd0, 3'd0);
    START = 1'b0; exp_run = 1'b1;
    fetch(16'h7001);
    cyc("hlt_t3", 8'h08, 3'd0, S_REG, 3'd0);
    exp_run = 1'b0;
    cyc("halted_0", 8'h01, 3'd0, 15'd0, 3'd0);
    cyc("halted_1", 8'h01, 3'd0, 15'd0, 3'd0);
    START = 1'b1;
    cyc("halt_start", 8'h01, 3'd0, 15'd0, 3'd0);
    START = 1'b0; exp_run = 1'b1;
    cyc("resume_t0", 8'h01, 3'd2, S_AR_LD, 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
